uart_rx_line: RTL and testbench

Line-oriented UART receiver. It is the receive counterpart of the existing hello-world transmit path. It oversamples the serial input at 16× baud, deframes 8N1 characters, and flags framing errors. Received characters are collected into a 16-byte line buffer until a newline (8'h0A) arrives, after which the line is held for a downstream reader until it is acknowledged.

---
 rtl/uart_rx_line_if.sv | 24 ++
 rtl/uart_rx_line.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_line.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_line_if.sv
// uart_rx_line_if: character and line-buffer signals of uart_rx_line.
//   slave  : the receiver (drives characters, line status, read data)
//   master : the downstream line reader (drives rd_addr and line_ack)
interface uart_rx_line_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       line_ready;
    logic [4:0] line_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       line_ack;
    logic       overflow;

    modport slave (
        output rx_byte, rx_valid, frame_err, line_ready, line_len, rd_data, overflow,
        input  rd_addr, line_ack
    );

    modport master (
        input  rx_byte, rx_valid, frame_err, line_ready, line_len, rd_data, overflow,
        output rd_addr, line_ack
    );
endinterface

// File: rtl/uart_rx_line.sv
// uart_rx_line: 16x oversampling 8N1 UART receiver feeding a 16-byte line
// buffer. A newline completes the line, which is held until line_ack.
//   RST_clk      : system clock, rising edge
//   RST_n        : asynchronous active-low reset
//   uart_rx_data : serial line, idle high, asynchronous
//   bus (slave)  : rx_byte/rx_valid/frame_err character outputs, line_ready,
//                  line_len, overflow, rd_addr -> rd_data, line_ack
//
// state       | meaning
// S_IDLE      | line idle, waiting for a falling edge
// S_START     | counting to the middle of the start bit
// S_DATA      | sampling 8 data bits, LSB first
// S_STOP      | counting to the middle of the stop bit
// S_WAIT_HIGH | framing error seen, waiting for the line to go high
module uart_rx_line #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic          RST_clk,
    input  logic          RST_n,
    input  logic          uart_rx_data,
    uart_rx_line_if.slave bus
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rxs_q, rxs_prev_q;
    logic [DW-1:0]  div_cnt_q;
    logic           tick, fall;
    logic [3:0]     sc_q, sc_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic           rx_valid_q, rx_valid_d;
    logic           frame_err_q, frame_err_d;

    logic [7:0]     line_buf_q [16];
    logic [4:0]     wp_q, wp_d;
    logic [4:0]     line_len_q, line_len_d;
    logic           line_ready_q, line_ready_d;
    logic           overflow_q, overflow_d;
    logic           wr_en;
    logic [3:0]     wr_idx;

    assign tick = (div_cnt_q == DW'(DIV - 1));
    assign fall = rxs_prev_q & ~rxs_q;

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            div_cnt_q  <= '0;
        end else begin
            rx_meta_q  <= uart_rx_data;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            div_cnt_q  <= tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    // state register (with the FSM's datapath registers)
    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            sc_q        <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (fall) state_d = S_START;
            S_START:     if (tick && sc_q == 4'd7) state_d = rxs_q ? S_IDLE : S_DATA;
            S_DATA:      if (tick && sc_q == 4'd15 && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:      if (tick && sc_q == 4'd15) state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // output / datapath logic
    always_comb begin
        sc_d        = sc_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: if (fall) sc_d = 4'd0;
            S_START: if (tick) begin
                if (sc_q == 4'd7) begin
                    sc_d  = 4'd0;
                    bit_d = 3'd0;
                end else begin
                    sc_d = sc_q + 4'd1;
                end
            end
            S_DATA: if (tick) begin
                if (sc_q == 4'd15) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
                sc_d = sc_q + 4'd1;   // 15 wraps to 0 at each bit boundary
            end
            S_STOP: if (tick) begin
                if (sc_q == 4'd15) begin
                    if (rxs_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                sc_d = sc_q + 4'd1;
            end
            default: ;
        endcase
    end

    // Line buffer: an ack on a held line is applied before the byte arriving
    // in the same cycle, so that byte starts the fresh line.
    always_comb begin
        logic ack_eff;
        ack_eff      = bus.line_ack & line_ready_q;
        line_ready_d = ack_eff ? 1'b0 : line_ready_q;
        line_len_d   = ack_eff ? 5'd0 : line_len_q;
        wp_d         = ack_eff ? 5'd0 : wp_q;
        overflow_d   = ack_eff ? 1'b0 : overflow_q;
        wr_en        = 1'b0;
        wr_idx       = wp_d[3:0];
        if (rx_valid_q) begin
            if (line_ready_d) begin
                overflow_d = 1'b1;
            end else if (rx_byte_q == 8'h0A) begin
                line_ready_d = 1'b1;
                line_len_d   = wp_d;
            end else if (!wp_d[4]) begin
                wr_en = 1'b1;
                wp_d  = wp_d + 5'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 16; i++) line_buf_q[i] <= 8'h00;
            wp_q         <= 5'd0;
            line_len_q   <= 5'd0;
            line_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (wr_en) line_buf_q[wr_idx] <= rx_byte_q;
            wp_q         <= wp_d;
            line_len_q   <= line_len_d;
            line_ready_q <= line_ready_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.rx_byte    = rx_byte_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.line_ready = line_ready_q;
    assign bus.line_len   = line_len_q;
    assign bus.overflow   = overflow_q;
    assign bus.rd_data    = ({1'b0, bus.rd_addr} < line_len_q) ? line_buf_q[bus.rd_addr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_line.sv
module tb_uart_rx_line;
    localparam int BITCLK = 64;   // DIV=4 -> 64 clocks per bit

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    uart_rx_line_if bus();

    uart_rx_line #(.CLK_FREQ(6_400_000), .BAUD(100_000)) dut (
        .RST_clk(clk), .RST_n(rst_n), .uart_rx_data(rx_line), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int wait_n;
    int ferr_before;
    logic [7:0] got_q[$];

    // reference line model
    logic [7:0] mline[$];
    bit mready = 0;
    bit movf = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) got_q.push_back(bus.rx_byte);
        if (bus.frame_err) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_char(input logic [7:0] c);
        if (mready) movf = 1;
        else if (c == 8'h0A) mready = 1;
        else if (mline.size() < 16) mline.push_back(c);
        else movf = 1;
    endtask

    task automatic model_reset();
        mline.delete();
        mready = 0;
        movf = 0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int nbits);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_line = f[i];
            repeat (BITCLK) @(posedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic send_char(input logic [7:0] c);
        got_q.delete();
        drive_frame(c, 1'b1, 10);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rx_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("rx_byte_pulse", got_q[0], c);
        chk("rx_byte_hold", bus.rx_byte, c);
        got_q.delete();
        model_char(c);
    endtask

    task automatic pulse_ack();
        @(negedge clk) bus.line_ack = 1'b1;
        @(negedge clk) bus.line_ack = 1'b0;
        if (mready) model_reset();
        @(negedge clk);
    endtask

    task automatic check_line(input string tag);
        logic [7:0] e;
        chk({tag, "_ready"}, bus.line_ready, mready);
        chk({tag, "_len"}, bus.line_len, mready ? mline.size() : 0);
        chk({tag, "_ovf"}, bus.overflow, movf);
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = a[3:0];
            #1;
            e = (mready && a < mline.size()) ? mline[a] : 8'h00;
            chk({tag, "_rd"}, bus.rd_data, e);
        end
        bus.rd_addr = 4'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_byte"}, bus.rx_byte, 8'h00);
        chk({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        chk({tag, "_frame_err"}, bus.frame_err, 1'b0);
        chk({tag, "_ready"}, bus.line_ready, 1'b0);
        chk({tag, "_len"}, bus.line_len, 5'd0);
        chk({tag, "_ovf"}, bus.overflow, 1'b0);
        chk({tag, "_rd"}, bus.rd_data, 8'h00);
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'h0A);
        return c;
    endfunction

    initial begin
        bus.rd_addr = 4'd0;
        bus.line_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // "hi\n"
        send_char(8'h68);
        send_char(8'h69);
        send_char(8'h0A);
        check_line("hi");
        pulse_ack();
        check_line("hi_ack");

        // glitch just under half a bit: rejected at the mid-start sample
        got_q.delete();
        ferr_before = ferr_cnt;
        rx_line = 1'b0;
        repeat (24) @(posedge clk);
        rx_line = 1'b1;
        repeat (200) @(posedge clk);
        chk("glitch_no_valid", got_q.size(), 0);
        chk("glitch_no_ferr", ferr_cnt, ferr_before);
        send_char(8'h55);

        // framing error followed by a 3-bit break, then a good frame
        ferr_before = ferr_cnt;
        got_q.delete();
        drive_frame(8'hA5, 1'b0, 10);
        rx_line = 1'b0;
        repeat (3 * BITCLK) @(posedge clk);
        rx_line = 1'b1;
        repeat (BITCLK) @(posedge clk);
        chk("ferr_count", ferr_cnt, ferr_before + 1);
        chk("ferr_no_valid", got_q.size(), 0);
        send_char(8'h31);

        // ack on an idle line is ignored
        pulse_ack();
        send_char(8'h0A);
        check_line("u1");
        pulse_ack();

        // overflow: 20 characters then newline
        for (int i = 0; i < 20; i++) send_char(rand_char());
        send_char(8'h0A);
        check_line("ovf");
        pulse_ack();
        check_line("ovf_ack");

        // random lines; the last one stays held
        for (int k = 0; k < 2; k++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int j = 0; j < n; j++) send_char(rand_char());
            send_char(8'h0A);
            check_line("rand");
            if (k == 0) pulse_ack();
        end

        // character while a line is held
        send_char(8'h78);
        check_line("held_x");

        // ack coinciding with rx_valid of 'y'
        got_q.delete();
        fork
            drive_frame(8'h79, 1'b1, 10);
            begin
                wait_n = 0;
                @(negedge clk);
                while (!bus.rx_valid && wait_n < 1000) begin
                    @(negedge clk);
                    wait_n++;
                end
                chk("sync_ack_rx_valid_seen", bus.rx_valid, 1'b1);
                bus.line_ack = 1'b1;
                @(negedge clk);
                bus.line_ack = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        chk("sync_ack_rx_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("sync_ack_rx_byte", got_q[0], 8'h79);
        got_q.delete();
        model_reset();
        model_char(8'h79);
        check_line("sync_ack");
        send_char(8'h0A);
        check_line("sync_ack_nl");

        // reset during data bit 4 of a frame
        drive_frame(8'h4B, 1'b1, 5);
        rx_line = 1'b0;                    // bit 4 of 8'h4B is 0
        repeat (BITCLK / 2) @(posedge clk);
        #2 rst_n = 1'b0;
        rx_line = 1'b1;
        #1 check_reset_outputs("midreset");
        repeat (10) @(posedge clk);
        check_reset_outputs("midreset_hold");
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        got_q.delete();
        repeat (20) @(posedge clk);
        send_char(8'h0A);
        check_line("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
